// File: rtl/irq_stim_pkg.sv
// Shared types and helpers for the interrupt stimulus generator.
// State encoding, fire_count saturation value and a lowest-set-bit picker.
package irq_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSERT   = 2'd1,
    ST_COOLDOWN = 2'd2
  } irq_state_e;

  localparam int         MAX_TRIG   = 8;
  localparam logic [7:0] FIRE_SAT   = 8'd255;

  // Scanning from the top down leaves the lowest set index as the final answer.
  function automatic logic [2:0] lowest_set(input logic [MAX_TRIG-1:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = MAX_TRIG - 1; i >= 0; i--) begin
      if (vec[i]) idx = i[2:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_trig_match.sv
// One trigger slot: holds its armed flag and flags a PC match while armed and enabled.
// Without re-arm, the first sampled hit disarms the slot until the next reset.
module irq_trig_match #(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] TRIG_PC = '0,
  parameter bit                REARM   = 1'b0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              enable_i,
  output logic              hit_o
);

  logic armed_q;

  assign hit_o = enable_i & armed_q & (addr_i == TRIG_PC);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      armed_q <= 1'b1;
    end else if (hit_o && !REARM) begin
      armed_q <= 1'b0;
    end
  end

endmodule

// File: rtl/irq_stim_gen.sv
// Interrupt stimulus generator: PC-matched triggers queue requests that are
// played out as fixed-length interrupt pulses separated by a cooldown gap.
module irq_stim_gen
  import irq_stim_pkg::*;
#(
  parameter int                         NUM_TRIG  = 4,
  parameter int                         ADDR_W    = 32,
  parameter logic [NUM_TRIG*ADDR_W-1:0] TRIG_PCS  = {NUM_TRIG{32'h00004198}},
  parameter int                         PULSE_LEN = 6,
  parameter int                         GAP       = 1,
  parameter bit                         REARM     = 1'b0
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic                enable_i,
  output logic                interrupt_o,
  output logic                busy_o,
  output logic [NUM_TRIG-1:0] pending_o,
  output logic [2:0]          last_src_o,
  output logic [7:0]          fire_count_o
);

  localparam int CNT_MAX = (PULSE_LEN > GAP) ? ((PULSE_LEN > 2) ? PULSE_LEN : 2)
                                             : ((GAP > 2) ? GAP : 2);
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] PULSE_RELOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_RELOAD   = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  irq_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                interrupt_q;
  logic                busy_q;
  logic [NUM_TRIG-1:0] pending_q, pending_d;
  logic [2:0]          last_src_q;
  logic [7:0]          fire_count_q;

  logic [NUM_TRIG-1:0] hit;
  logic [NUM_TRIG-1:0] req;
  logic [MAX_TRIG-1:0] reqPad;
  logic [2:0]          sel;

  for (genvar i = 0; i < NUM_TRIG; i++) begin : g_trig
    irq_trig_match #(
      .ADDR_W (ADDR_W),
      .TRIG_PC(TRIG_PCS[i*ADDR_W +: ADDR_W]),
      .REARM  (REARM)
    ) u_match (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .addr_i  (addr_i),
      .enable_i(enable_i),
      .hit_o   (hit[i])
    );
  end

  assign req = pending_q | hit;

  always_comb begin
    reqPad = '0;
    reqPad[NUM_TRIG-1:0] = req;
  end

  assign sel = lowest_set(reqPad);

  // New hits always queue; the one picked from IDLE is dropped in the same edge.
  always_comb begin
    pending_d = pending_q | hit;
    if (state_q == ST_IDLE && (|req)) begin
      for (int i = 0; i < NUM_TRIG; i++) begin
        if (sel == i[2:0]) pending_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      interrupt_q  <= 1'b0;
      busy_q       <= 1'b0;
      pending_q    <= '0;
      last_src_q   <= 3'd0;
      fire_count_q <= 8'd0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            state_q     <= ST_ASSERT;
            interrupt_q <= 1'b1;
            busy_q      <= 1'b1;
            cnt_q       <= PULSE_RELOAD;
            last_src_q  <= sel;
            if (fire_count_q != FIRE_SAT) fire_count_q <= fire_count_q + 8'd1;
          end
        end
        ST_ASSERT: begin
          if (cnt_q == '0) begin
            interrupt_q <= 1'b0;
            if (GAP > 0) begin
              state_q <= ST_COOLDOWN;
              cnt_q   <= GAP_RELOAD;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_COOLDOWN: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          interrupt_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign interrupt_o  = interrupt_q;
  assign busy_o       = busy_q;
  assign pending_o    = pending_q;
  assign last_src_o   = last_src_q;
  assign fire_count_o = fire_count_q;

endmodule

// File: tb/tb_irq_stim_gen.sv
// Directed bench for irq_stim_gen: three configurations, scoreboarded per cycle.
// Expected values are queued with a target cycle when stimulus is applied.
module tb_irq_stim_gen;

  localparam int SIG_INT  = 0;
  localparam int SIG_BUSY = 1;
  localparam int SIG_PEND = 2;
  localparam int SIG_SRC  = 3;
  localparam int SIG_CNT  = 4;

  logic        clk;
  logic        rst0, rst1, rst2;
  logic [31:0] addr0, addr1, addr2;
  logic        en0, en1, en2;
  logic        int0, int1, int2;
  logic        busy0, busy1, busy2;
  logic [3:0]  pend0, pend1, pend2;
  logic [2:0]  src0, src1, src2;
  logic [7:0]  cnt0, cnt1, cnt2;

  typedef struct {
    int          cyc;
    int          dut;
    int          kind;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   cycleNo     = 0;
  int   vectors     = 0;
  int   miscompares = 0;

  irq_stim_gen u_dut0 (
    .clk_i(clk), .reset_i(rst0), .addr_i(addr0), .enable_i(en0),
    .interrupt_o(int0), .busy_o(busy0), .pending_o(pend0),
    .last_src_o(src0), .fire_count_o(cnt0)
  );

  irq_stim_gen #(
    .TRIG_PCS({32'h00003008, 32'h00003004, 32'h00003000, 32'h00002FFC}),
    .PULSE_LEN(6), .GAP(1), .REARM(1'b0)
  ) u_dut1 (
    .clk_i(clk), .reset_i(rst1), .addr_i(addr1), .enable_i(en1),
    .interrupt_o(int1), .busy_o(busy1), .pending_o(pend1),
    .last_src_o(src1), .fire_count_o(cnt1)
  );

  irq_stim_gen #(
    .TRIG_PCS({32'h00000400, 32'h00000300, 32'h00000200, 32'h00000100}),
    .PULSE_LEN(2), .GAP(0), .REARM(1'b1)
  ) u_dut2 (
    .clk_i(clk), .reset_i(rst2), .addr_i(addr2), .enable_i(en2),
    .interrupt_o(int2), .busy_o(busy2), .pending_o(pend2),
    .last_src_o(src2), .fire_count_o(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] observe(input int d, input int k);
    logic [31:0] v;
    v = '0;
    case (d)
      0: case (k)
           SIG_INT:  v = 32'(int0);
           SIG_BUSY: v = 32'(busy0);
           SIG_PEND: v = 32'(pend0);
           SIG_SRC:  v = 32'(src0);
           default:  v = 32'(cnt0);
         endcase
      1: case (k)
           SIG_INT:  v = 32'(int1);
           SIG_BUSY: v = 32'(busy1);
           SIG_PEND: v = 32'(pend1);
           SIG_SRC:  v = 32'(src1);
           default:  v = 32'(cnt1);
         endcase
      default: case (k)
           SIG_INT:  v = 32'(int2);
           SIG_BUSY: v = 32'(busy2);
           SIG_PEND: v = 32'(pend2);
           SIG_SRC:  v = 32'(src2);
           default:  v = 32'(cnt2);
         endcase
    endcase
    return v;
  endfunction

  task automatic expectAt(input int off, input int d, input int k,
                          input logic [31:0] v, input string tag);
    exp_t e;
    int   idx;
    e.cyc  = cycleNo + off;
    e.dut  = d;
    e.kind = k;
    e.exp  = v;
    e.tag  = tag;
    idx = sbq.size();
    while (idx > 0 && sbq[idx-1].cyc > e.cyc) idx--;
    sbq.insert(idx, e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [31:0] obs;
    while (sbq.size() > 0 && sbq[0].cyc <= cycleNo) begin
      e   = sbq.pop_front();
      obs = observe(e.dut, e.kind);
      vectors++;
      assert (obs === e.exp) else begin
        miscompares++;
        $error("[TB] FAIL %s dut%0d cycle %0d observed=%0h expected=%0h",
               e.tag, e.dut, cycleNo, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycleNo++;
    checkOutput();
  endtask

  task automatic applyStimulus(input int d, input logic [31:0] a, input logic en);
    case (d)
      0:       begin addr0 = a; en0 = en; end
      1:       begin addr1 = a; en1 = en; end
      default: begin addr2 = a; en2 = en; end
    endcase
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    applyStimulus(0, 32'h0, 1'b1);
    applyStimulus(1, 32'h0, 1'b1);
    applyStimulus(2, 32'h0, 1'b1);
    tick();
    tick();

    for (int d = 0; d < 3; d++) begin
      expectAt(0, d, SIG_INT,  32'h0, "rst_interrupt");
      expectAt(0, d, SIG_BUSY, 32'h0, "rst_busy");
      expectAt(0, d, SIG_PEND, 32'h0, "rst_pending");
      expectAt(0, d, SIG_SRC,  32'h0, "rst_last_src");
      expectAt(0, d, SIG_CNT,  32'h0, "rst_fire_count");
    end
    checkOutput();
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    $display("[TB] all four triggers share 0x4198: one sampled visit queues four pulses");
    applyStimulus(0, 32'h00004198, 1'b1);
    for (int p = 0; p < 4; p++) begin
      for (int o = 0; o < 8; o++) expectAt(1 + 8*p + o, 0, SIG_INT, 32'(o < 6), "t1_interrupt");
      expectAt(1 + 8*p, 0, SIG_SRC, 32'(p), "t1_last_src");
      expectAt(1 + 8*p, 0, SIG_CNT, 32'(p + 1), "t1_fire_count");
    end
    expectAt(1,  0, SIG_PEND, 32'hE, "t1_pending_queued");
    expectAt(7,  0, SIG_BUSY, 32'h1, "t1_busy_cooldown");
    expectAt(8,  0, SIG_BUSY, 32'h0, "t1_busy_idle");
    expectAt(25, 0, SIG_PEND, 32'h0, "t1_pending_drained");
    tick();
    applyStimulus(0, 32'h0, 1'b1);
    repeat (31) tick();

    applyStimulus(0, 32'h00004198, 1'b1);
    for (int o = 1; o <= 6; o++) expectAt(o, 0, SIG_INT, 32'h0, "t1_no_rearm_interrupt");
    expectAt(6, 0, SIG_CNT,  32'h4, "t1_no_rearm_fire_count");
    expectAt(6, 0, SIG_PEND, 32'h0, "t1_no_rearm_pending");
    repeat (6) tick();
    applyStimulus(0, 32'h0, 1'b1);

    $display("[TB] consecutive PCs hit triggers 0,1,2 in order");
    applyStimulus(1, 32'h00002FFC, 1'b1);
    for (int p = 0; p < 3; p++) begin
      for (int o = 0; o < 8; o++) expectAt(1 + 8*p + o, 1, SIG_INT, 32'(o < 6), "t2_interrupt");
      expectAt(1 + 8*p, 1, SIG_SRC, 32'(p), "t2_last_src");
      expectAt(1 + 8*p, 1, SIG_CNT, 32'(p + 1), "t2_fire_count");
    end
    expectAt(2,  1, SIG_PEND, 32'h2, "t2_pending_one");
    expectAt(3,  1, SIG_PEND, 32'h6, "t2_pending_two");
    expectAt(9,  1, SIG_PEND, 32'h4, "t2_pending_after_second");
    expectAt(17, 1, SIG_PEND, 32'h0, "t2_pending_empty");
    expectAt(24, 1, SIG_BUSY, 32'h0, "t2_busy_idle");
    tick();
    applyStimulus(1, 32'h00003000, 1'b1);
    tick();
    applyStimulus(1, 32'h00003004, 1'b1);
    tick();
    applyStimulus(1, 32'h0, 1'b1);
    repeat (21) tick();

    $display("[TB] reset asserted in the middle of a pulse");
    rst1 = 1'b1;
    #1;
    rst1 = 1'b0;
    applyStimulus(1, 32'h00003008, 1'b1);
    for (int o = 1; o <= 3; o++) expectAt(o, 1, SIG_INT, 32'h1, "t3_pulse_before_reset");
    expectAt(1, 1, SIG_SRC, 32'h3, "t3_last_src");
    expectAt(1, 1, SIG_CNT, 32'h1, "t3_fire_count");
    tick();
    applyStimulus(1, 32'h0, 1'b1);
    tick();
    tick();
    rst1 = 1'b1;
    #1;
    expectAt(0, 1, SIG_INT,  32'h0, "t3_async_interrupt");
    expectAt(0, 1, SIG_BUSY, 32'h0, "t3_async_busy");
    expectAt(0, 1, SIG_CNT,  32'h0, "t3_async_fire_count");
    checkOutput();
    #1;
    rst1 = 1'b0;
    applyStimulus(1, 32'h00003008, 1'b1);
    for (int o = 1; o <= 8; o++) expectAt(o, 1, SIG_INT, 32'(o <= 6), "t3_refire_interrupt");
    expectAt(1, 1, SIG_SRC, 32'h3, "t3_refire_last_src");
    expectAt(1, 1, SIG_CNT, 32'h1, "t3_refire_fire_count");
    tick();
    applyStimulus(1, 32'h0, 1'b1);
    repeat (7) tick();

    $display("[TB] enable low masks new matches");
    applyStimulus(1, 32'h00003000, 1'b0);
    for (int o = 1; o <= 3; o++) begin
      expectAt(o, 1, SIG_INT,  32'h0, "t4_disabled_interrupt");
      expectAt(o, 1, SIG_PEND, 32'h0, "t4_disabled_pending");
    end
    expectAt(3, 1, SIG_CNT, 32'h1, "t4_disabled_fire_count");
    repeat (3) tick();
    applyStimulus(1, 32'h00003000, 1'b1);
    expectAt(1, 1, SIG_INT,  32'h1, "t4_enabled_interrupt");
    expectAt(1, 1, SIG_SRC,  32'h1, "t4_enabled_last_src");
    expectAt(1, 1, SIG_CNT,  32'h2, "t4_enabled_fire_count");
    expectAt(1, 1, SIG_PEND, 32'h0, "t4_enabled_pending");
    expectAt(6, 1, SIG_INT,  32'h1, "t4_pulse_end_high");
    expectAt(7, 1, SIG_INT,  32'h0, "t4_pulse_end_low");
    tick();
    applyStimulus(1, 32'h0, 1'b1);
    repeat (7) tick();

    $display("[TB] re-arm with two-cycle pulses and no gap");
    applyStimulus(2, 32'h00000100, 1'b1);
    for (int n = 0; n < 4; n++) begin
      expectAt(1 + 3*n, 2, SIG_INT, 32'h1, "t5_interrupt_hi1");
      expectAt(2 + 3*n, 2, SIG_INT, 32'h1, "t5_interrupt_hi2");
      expectAt(3 + 3*n, 2, SIG_INT, 32'h0, "t5_interrupt_lo");
      expectAt(1 + 3*n, 2, SIG_CNT, 32'(n + 1), "t5_fire_count");
    end
    expectAt(13, 2, SIG_INT,  32'h0, "t5_quiet_interrupt");
    expectAt(13, 2, SIG_CNT,  32'h4, "t5_quiet_fire_count");
    expectAt(13, 2, SIG_PEND, 32'h0, "t5_quiet_pending");
    expectAt(13, 2, SIG_BUSY, 32'h0, "t5_quiet_busy");
    repeat (10) tick();
    applyStimulus(2, 32'h0, 1'b1);
    repeat (3) tick();

    $display("[TB] fire_count saturation");
    applyStimulus(2, 32'h00000100, 1'b1);
    for (int n = 1; n <= 253; n++) begin
      expectAt(3*n - 2, 2, SIG_INT, 32'h1, "t6_interrupt");
      expectAt(3*n - 2, 2, SIG_CNT, 32'(((4 + n) > 255) ? 255 : (4 + n)), "t6_fire_count");
    end
    repeat (757) tick();
    applyStimulus(2, 32'h0, 1'b1);
    expectAt(1, 2, SIG_INT, 32'h1, "t6_last_pulse_high");
    for (int o = 2; o <= 5; o++) expectAt(o, 2, SIG_INT, 32'h0, "t6_after_interrupt");
    expectAt(5, 2, SIG_CNT,  32'hFF, "t6_saturated");
    expectAt(5, 2, SIG_PEND, 32'h0, "t6_pending");
    repeat (5) tick();

    vectors++;
    assert (sbq.size() == 0) else begin
      miscompares++;
      $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
